// File: rtl/avalon_stream_guard.sv
// Avalon-ST stream guard: repairs an untrusted packet stream into a legal one.
// Fully registered output with a one-entry skid; saturating error counters.
module avalon_stream_guard #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_MSG_BEATS       = 256,
  parameter int UNEXP_SOP_MODE      = 0,
  parameter int CNT_WIDTH           = 16,
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES,
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1,
  localparam int BW = $clog2(MAX_MSG_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        untrusted_msg_data,
  input  logic                 untrusted_msg_valid,
  input  logic                 untrusted_msg_sop,
  input  logic                 untrusted_msg_eop,
  input  logic [EW-1:0]        untrusted_msg_empty,
  output logic                 untrusted_msg_rdy,
  output logic [DW-1:0]        enforced_msg_data,
  output logic                 enforced_msg_valid,
  output logic                 enforced_msg_sop,
  output logic                 enforced_msg_eop,
  output logic [EW-1:0]        enforced_msg_empty,
  input  logic                 enforced_msg_rdy,
  input  logic                 clear_counters,
  output logic                 missing_sop,
  output logic                 unexpected_sop,
  output logic                 length_overflow,
  output logic [CNT_WIDTH-1:0] missing_sop_cnt,
  output logic [CNT_WIDTH-1:0] unexpected_sop_cnt,
  output logic [CNT_WIDTH-1:0] overflow_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, IN_MSG = 2'd1, DROP_TAIL = 2'd2} state_t;

  state_t          state, next_state;
  logic [BW-1:0]   beat_cnt, next_cnt;
  logic            accept, fwd, fwd_sop, fwd_eop, miss, unexp, ovf;
  logic [EW-1:0]   fwd_empty, shaped_empty;
  logic [DW-1:0]   shaped_data;
  logic            rdy_q, skid_valid, skid_next;
  logic [DW-1:0]   skid_data;
  logic            skid_sop, skid_eop;
  logic [EW-1:0]   skid_empty;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    else    return v + CNT_WIDTH'(1);
  endfunction

  assign accept            = untrusted_msg_valid && rdy_q;
  assign untrusted_msg_rdy = rdy_q;

  // Message framing decisions for the beat being accepted this cycle
  always_comb begin
    next_state = state;
    next_cnt   = beat_cnt;
    fwd        = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = untrusted_msg_eop;
    fwd_empty  = untrusted_msg_empty;
    miss       = 1'b0;
    unexp      = 1'b0;
    ovf        = 1'b0;
    if (accept) begin
      case (state)
        IN_MSG: begin
          unexp = untrusted_msg_sop;
          if (untrusted_msg_sop && (UNEXP_SOP_MODE == 1)) begin
            next_cnt = beat_cnt;
          end else begin
            fwd      = 1'b1;
            next_cnt = beat_cnt + BW'(1);
            if (untrusted_msg_eop) begin
              next_state = IDLE;
              next_cnt   = '0;
            end else if (beat_cnt + BW'(1) == BW'(MAX_MSG_BEATS)) begin
              fwd_eop    = 1'b1;
              fwd_empty  = '0;
              ovf        = 1'b1;
              next_state = DROP_TAIL;
            end else begin
              next_state = IN_MSG;
            end
          end
        end
        // IDLE and DROP_TAIL both open a new message on sop; an illegal
        // encoding falls back to dropping until the next eop
        default: begin
          if (untrusted_msg_sop) begin
            fwd        = 1'b1;
            fwd_sop    = 1'b1;
            next_cnt   = BW'(1);
            next_state = untrusted_msg_eop ? IDLE : IN_MSG;
          end else begin
            miss       = (state == IDLE);
            next_state = (untrusted_msg_eop || state == IDLE) ? IDLE : DROP_TAIL;
          end
        end
      endcase
    end else begin
      next_state = state;
    end
  end

  // Empty only applies to eop beats; bytes below empty are zeroed
  always_comb begin
    shaped_empty = fwd_eop ? fwd_empty : '0;
    shaped_data  = untrusted_msg_data;
    for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
      if (i < int'(shaped_empty)) shaped_data[i*8 +: 8] = 8'h00;
      else                        shaped_data[i*8 +: 8] = untrusted_msg_data[i*8 +: 8];
    end
  end

  // Skid occupancy after this edge; drives the registered upstream ready
  always_comb begin
    if (skid_valid) skid_next = !enforced_msg_rdy;
    else            skid_next = fwd && enforced_msg_valid && !enforced_msg_rdy;
  end

  // Framing state and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= next_state;
      beat_cnt <= next_cnt;
    end
  end

  // Output register and skid entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q              <= 1'b0;
      skid_valid         <= 1'b0;
      skid_data          <= '0;
      skid_sop           <= 1'b0;
      skid_eop           <= 1'b0;
      skid_empty         <= '0;
      enforced_msg_valid <= 1'b0;
      enforced_msg_data  <= '0;
      enforced_msg_sop   <= 1'b0;
      enforced_msg_eop   <= 1'b0;
      enforced_msg_empty <= '0;
    end else begin
      rdy_q <= !skid_next;
      if (skid_valid) begin
        if (enforced_msg_rdy) begin
          enforced_msg_data  <= skid_data;
          enforced_msg_sop   <= skid_sop;
          enforced_msg_eop   <= skid_eop;
          enforced_msg_empty <= skid_empty;
          skid_valid         <= 1'b0;
        end
      end else if (fwd) begin
        if (!enforced_msg_valid || enforced_msg_rdy) begin
          enforced_msg_valid <= 1'b1;
          enforced_msg_data  <= shaped_data;
          enforced_msg_sop   <= fwd_sop;
          enforced_msg_eop   <= fwd_eop;
          enforced_msg_empty <= shaped_empty;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= shaped_data;
          skid_sop   <= fwd_sop;
          skid_eop   <= fwd_eop;
          skid_empty <= shaped_empty;
        end
      end else if (enforced_msg_rdy) begin
        enforced_msg_valid <= 1'b0;
      end
    end
  end

  // Event flags and saturating counters; clear beats a same-cycle event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      missing_sop        <= 1'b0;
      unexpected_sop     <= 1'b0;
      length_overflow    <= 1'b0;
      missing_sop_cnt    <= '0;
      unexpected_sop_cnt <= '0;
      overflow_cnt       <= '0;
    end else begin
      missing_sop     <= miss;
      unexpected_sop  <= unexp;
      length_overflow <= ovf;
      if (clear_counters) begin
        missing_sop_cnt    <= '0;
        unexpected_sop_cnt <= '0;
        overflow_cnt       <= '0;
      end else begin
        if (miss)  missing_sop_cnt    <= sat_inc(missing_sop_cnt);
        if (unexp) unexpected_sop_cnt <= sat_inc(unexpected_sop_cnt);
        if (ovf)   overflow_cnt       <= sat_inc(overflow_cnt);
      end
    end
  end

endmodule

// File: tb/tb_avalon_stream_guard.sv
// Directed bench for avalon_stream_guard: two instances (unexpected-sop mode 0
// and mode 1), 8-byte beats, 4-beat message limit, 2-bit counters.
module tb_avalon_stream_guard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [2:0]  in_empty = '0;
  logic        sel1 = 1'b0;
  logic        out_rdy = 1'b1;
  logic        clr = 1'b0;

  logic        v0, v1, in_rdy0, in_rdy1, cur_rdy;
  logic [63:0] o_data0, o_data1;
  logic        o_valid0, o_sop0, o_eop0, o_valid1, o_sop1, o_eop1;
  logic [2:0]  o_empty0, o_empty1;
  logic        f_miss0, f_unexp0, f_ovf0, f_miss1, f_unexp1, f_ovf1;
  logic [1:0]  c_miss0, c_unexp0, c_ovf0, c_miss1, c_unexp1, c_ovf1;

  assign v0      = in_valid && !sel1;
  assign v1      = in_valid && sel1;
  assign cur_rdy = sel1 ? in_rdy1 : in_rdy0;

  always #5 clk = ~clk;

  avalon_stream_guard #(.DATA_WIDTH_IN_BYTES(8), .MAX_MSG_BEATS(4), .UNEXP_SOP_MODE(0), .CNT_WIDTH(2)) dut0 (
    .clk(clk), .rst(rst),
    .untrusted_msg_data(in_data), .untrusted_msg_valid(v0), .untrusted_msg_sop(in_sop),
    .untrusted_msg_eop(in_eop), .untrusted_msg_empty(in_empty), .untrusted_msg_rdy(in_rdy0),
    .enforced_msg_data(o_data0), .enforced_msg_valid(o_valid0), .enforced_msg_sop(o_sop0),
    .enforced_msg_eop(o_eop0), .enforced_msg_empty(o_empty0), .enforced_msg_rdy(out_rdy),
    .clear_counters(clr), .missing_sop(f_miss0), .unexpected_sop(f_unexp0), .length_overflow(f_ovf0),
    .missing_sop_cnt(c_miss0), .unexpected_sop_cnt(c_unexp0), .overflow_cnt(c_ovf0));

  avalon_stream_guard #(.DATA_WIDTH_IN_BYTES(8), .MAX_MSG_BEATS(4), .UNEXP_SOP_MODE(1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst),
    .untrusted_msg_data(in_data), .untrusted_msg_valid(v1), .untrusted_msg_sop(in_sop),
    .untrusted_msg_eop(in_eop), .untrusted_msg_empty(in_empty), .untrusted_msg_rdy(in_rdy1),
    .enforced_msg_data(o_data1), .enforced_msg_valid(o_valid1), .enforced_msg_sop(o_sop1),
    .enforced_msg_eop(o_eop1), .enforced_msg_empty(o_empty1), .enforced_msg_rdy(out_rdy),
    .clear_counters(clr), .missing_sop(f_miss1), .unexpected_sop(f_unexp1), .length_overflow(f_ovf1),
    .missing_sop_cnt(c_miss1), .unexpected_sop_cnt(c_unexp1), .overflow_cnt(c_ovf1));

  int vectors = 0;
  int fails   = 0;

  // Output beats captured as {sop, eop, empty, data}
  logic [68:0] q0[$];
  logic [68:0] q1[$];
  int n_miss0 = 0, n_unexp0 = 0, n_ovf0 = 0, n_unexp1 = 0;

  logic        bp_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [68:0] prev_beat = '0;
  int acc = 0, del = 0, stall_err = 0, rdy_err = 0, stall_seen = 0, rdy_low_seen = 0;

  // Monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (o_valid0 && out_rdy) q0.push_back({o_sop0, o_eop0, o_empty0, o_data0});
    if (o_valid1 && out_rdy) q1.push_back({o_sop1, o_eop1, o_empty1, o_data1});
    if (f_miss0)  n_miss0++;
    if (f_unexp0) n_unexp0++;
    if (f_ovf0)   n_ovf0++;
    if (f_unexp1) n_unexp1++;
    if (bp_chk) begin
      if (prev_stall && (!o_valid0 || {o_sop0, o_eop0, o_empty0, o_data0} != prev_beat)) stall_err++;
      prev_stall = o_valid0 && !out_rdy;
      prev_beat  = {o_sop0, o_eop0, o_empty0, o_data0};
      if (prev_stall) stall_seen++;
      if (in_rdy0 !== ((acc - del) < 2)) rdy_err++;
      if (!in_rdy0) rdy_low_seen++;
      if (v0 && in_rdy0) acc++;
      if (o_valid0 && out_rdy) del++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic s, input logic e, input logic [2:0] emp, input logic [63:0] d);
    int n;
    in_sop = s; in_eop = e; in_empty = emp; in_data = d; in_valid = 1'b1;
    n = 0;
    while (!cur_rdy && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      vectors++; fails++;
      $display("FAIL send_timeout: upstream rdy still %b after %0d cycles, required 1", cur_rdy, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle(3);
    vectors++;
    if ({o_valid0, o_sop0, o_eop0, o_empty0, o_data0} !== 69'd0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0", {o_valid0, o_sop0, o_eop0, o_empty0, o_data0});
    end
    vectors++;
    if (in_rdy0 !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b required 0", in_rdy0); end
    vectors++;
    if ({f_miss0, f_unexp0, f_ovf0, c_miss0, c_unexp0, c_ovf0} !== 9'd0) begin
      fails++; $display("FAIL reset_flags_cnts: got %b required 0", {f_miss0, f_unexp0, f_ovf0, c_miss0, c_unexp0, c_ovf0});
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_clean;
    logic [68:0] exp [3];
    exp[0] = {1'b1, 1'b0, 3'd0, 64'h0102030405060708};
    exp[1] = {1'b0, 1'b0, 3'd0, 64'h1112131415161718};
    exp[2] = {1'b0, 1'b1, 3'd5, 64'hAABBCC0000000000};
    q0.delete();
    send(1'b1, 1'b0, 3'd3, 64'h0102030405060708);
    vectors++;
    if (o_valid0 !== 1'b1 || o_data0 !== 64'h0102030405060708) begin
      fails++; $display("FAIL clean_latency: valid %b data %h required 1 0102030405060708", o_valid0, o_data0);
    end
    send(1'b0, 1'b0, 3'd7, 64'h1112131415161718);
    send(1'b0, 1'b1, 3'd5, 64'hAABBCCDDEEFF0011);
    idle(3);
    vectors++;
    if (q0.size() != 3) begin fails++; $display("FAIL clean_count: got %0d beats required 3", q0.size()); end
    for (int i = 0; i < 3 && i < q0.size(); i++) begin
      vectors++;
      if (q0[i] !== exp[i]) begin fails++; $display("FAIL clean_beat%0d: got %h required %h", i, q0[i], exp[i]); end
    end
    vectors++;
    if (n_miss0 + n_unexp0 + n_ovf0 != 0) begin
      fails++; $display("FAIL clean_flags: got %0d pulses required 0", n_miss0 + n_unexp0 + n_ovf0);
    end
  endtask

  task automatic test_missing_sop;
    q0.delete();
    send(1'b0, 1'b0, 3'd0, 64'h00000000DEAD0001);
    send(1'b0, 1'b1, 3'd0, 64'h00000000DEAD0002);
    send(1'b1, 1'b1, 3'd2, 64'hCAFEBABE12345678);
    idle(3);
    vectors++;
    if (n_miss0 != 2) begin fails++; $display("FAIL miss_pulses: got %0d required 2", n_miss0); end
    vectors++;
    if (c_miss0 !== 2'd2) begin fails++; $display("FAIL miss_cnt: got %0d required 2", c_miss0); end
    vectors++;
    if (q0.size() != 1) begin fails++; $display("FAIL miss_count: got %0d beats required 1", q0.size()); end
    else begin
      vectors++;
      if (q0[0] !== {1'b1, 1'b1, 3'd2, 64'hCAFEBABE12340000}) begin
        fails++; $display("FAIL miss_beat: got %h required %h", q0[0], {1'b1, 1'b1, 3'd2, 64'hCAFEBABE12340000});
      end
    end
  endtask

  task automatic test_unexp_modes;
    logic [68:0] e0 [3];
    logic [68:0] e1 [2];
    e0[0] = {1'b1, 1'b0, 3'd0, 64'hA0}; e0[1] = {1'b0, 1'b0, 3'd0, 64'hB0}; e0[2] = {1'b0, 1'b1, 3'd0, 64'hC0};
    e1[0] = {1'b1, 1'b0, 3'd0, 64'hA0}; e1[1] = {1'b0, 1'b1, 3'd0, 64'hC0};
    q0.delete(); q1.delete();
    for (int m = 0; m < 2; m++) begin
      sel1 = (m == 1);
      send(1'b1, 1'b0, 3'd0, 64'hA0);
      send(1'b1, 1'b0, 3'd0, 64'hB0);
      send(1'b0, 1'b1, 3'd0, 64'hC0);
      idle(3);
    end
    sel1 = 1'b0;
    vectors++;
    if (q0.size() != 3) begin fails++; $display("FAIL mode0_count: got %0d required 3", q0.size()); end
    for (int i = 0; i < 3 && i < q0.size(); i++) begin
      vectors++;
      if (q0[i] !== e0[i]) begin fails++; $display("FAIL mode0_beat%0d: got %h required %h", i, q0[i], e0[i]); end
    end
    vectors++;
    if (q1.size() != 2) begin fails++; $display("FAIL mode1_count: got %0d required 2", q1.size()); end
    for (int i = 0; i < 2 && i < q1.size(); i++) begin
      vectors++;
      if (q1[i] !== e1[i]) begin fails++; $display("FAIL mode1_beat%0d: got %h required %h", i, q1[i], e1[i]); end
    end
    vectors++;
    if (c_unexp0 !== 2'd1 || n_unexp0 != 1) begin
      fails++; $display("FAIL mode0_unexp: cnt %0d pulses %0d required 1 1", c_unexp0, n_unexp0);
    end
    vectors++;
    if (c_unexp1 !== 2'd1 || n_unexp1 != 1) begin
      fails++; $display("FAIL mode1_unexp: cnt %0d pulses %0d required 1 1", c_unexp1, n_unexp1);
    end
  endtask

  task automatic test_overflow;
    int miss_before;
    miss_before = n_miss0;
    q0.delete();
    send(1'b1, 1'b0, 3'd0, 64'hD1);
    send(1'b0, 1'b0, 3'd0, 64'hD2);
    send(1'b0, 1'b0, 3'd0, 64'hD3);
    send(1'b0, 1'b0, 3'd4, 64'hD4);
    send(1'b0, 1'b0, 3'd0, 64'hD5);
    send(1'b0, 1'b1, 3'd3, 64'hD6);
    idle(3);
    vectors++;
    if (q0.size() != 4) begin fails++; $display("FAIL ovf_count: got %0d required 4", q0.size()); end
    else begin
      vectors++;
      if (q0[3] !== {1'b0, 1'b1, 3'd0, 64'hD4}) begin
        fails++; $display("FAIL ovf_last: got %h required %h", q0[3], {1'b0, 1'b1, 3'd0, 64'hD4});
      end
    end
    vectors++;
    if (n_ovf0 != 1 || c_ovf0 !== 2'd1) begin fails++; $display("FAIL ovf_flag: pulses %0d cnt %0d required 1 1", n_ovf0, c_ovf0); end
    vectors++;
    if (n_miss0 != miss_before) begin fails++; $display("FAIL ovf_tail_silent: got %0d miss pulses required %0d", n_miss0, miss_before); end
    q0.delete();
    send(1'b1, 1'b0, 3'd0, 64'hE1);
    send(1'b0, 1'b0, 3'd0, 64'hE2);
    send(1'b0, 1'b0, 3'd0, 64'hE3);
    send(1'b0, 1'b1, 3'd1, 64'h0807060504030201);
    idle(3);
    vectors++;
    if (q0.size() != 4) begin fails++; $display("FAIL exact_count: got %0d required 4", q0.size()); end
    else begin
      vectors++;
      if (q0[3] !== {1'b0, 1'b1, 3'd1, 64'h0807060504030200}) begin
        fails++; $display("FAIL exact_last: got %h required %h", q0[3], {1'b0, 1'b1, 3'd1, 64'h0807060504030200});
      end
    end
    vectors++;
    if (n_ovf0 != 1) begin fails++; $display("FAIL exact_no_ovf: got %0d pulses required 1", n_ovf0); end
  endtask

  task automatic test_back_to_back;
    logic done;
    logic [68:0] e;
    done = 1'b0;
    q0.delete();
    acc = 0; del = 0; prev_stall = 1'b0;
    bp_chk = 1'b1;
    fork
      begin
        for (int i = 0; i < 50; i++) send(1'b1, 1'b1, 3'd0, 64'h1000 + 64'(i));
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_rdy = ($urandom_range(0, 1) == 1); end
      end
    join
    out_rdy = 1'b1;
    idle(5);
    bp_chk = 1'b0;
    vectors++;
    if (q0.size() != 50) begin fails++; $display("FAIL bp_count: got %0d required 50", q0.size()); end
    for (int i = 0; i < 50 && i < q0.size(); i++) begin
      e = {1'b1, 1'b1, 3'd0, 64'h1000 + 64'(i)};
      vectors++;
      if (q0[i] !== e) begin fails++; $display("FAIL bp_beat%0d: got %h required %h", i, q0[i], e); end
    end
    vectors++;
    if (stall_err != 0) begin fails++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stall_err); end
    vectors++;
    if (rdy_err != 0) begin fails++; $display("FAIL bp_rdy: got %0d rdy vs occupancy errors required 0", rdy_err); end
    vectors++;
    if (stall_seen == 0 || rdy_low_seen == 0) begin
      fails++; $display("FAIL bp_coverage: stalls %0d rdy_low %0d required both nonzero", stall_seen, rdy_low_seen);
    end
  endtask

  task automatic test_counters;
    int p;
    clr = 1'b1; idle(1); clr = 1'b0;
    vectors++;
    if ({c_miss0, c_unexp0, c_ovf0} !== 6'd0) begin
      fails++; $display("FAIL clear: got %b required 0", {c_miss0, c_unexp0, c_ovf0});
    end
    p = n_miss0;
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 3'd0, 64'h55);
    idle(2);
    vectors++;
    if (c_miss0 !== 2'd3 || n_miss0 - p != 5) begin
      fails++; $display("FAIL saturate: cnt %0d pulses %0d required 3 5", c_miss0, n_miss0 - p);
    end
    clr = 1'b1;
    send(1'b0, 1'b0, 3'd0, 64'h66);
    clr = 1'b0;
    vectors++;
    if (c_miss0 !== 2'd0 || f_miss0 !== 1'b1) begin
      fails++; $display("FAIL clear_wins: cnt %0d flag %b required 0 1", c_miss0, f_miss0);
    end
  endtask

  task automatic test_reset_mid_msg;
    int u;
    send(1'b1, 1'b0, 3'd0, 64'hF1);
    send(1'b0, 1'b0, 3'd0, 64'hF2);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({o_valid0, o_sop0, o_eop0, o_empty0, o_data0, in_rdy0} !== 70'd0) begin
      fails++; $display("FAIL midreset_outputs: got %h required 0", {o_valid0, o_sop0, o_eop0, o_empty0, o_data0, in_rdy0});
    end
    idle(2);
    rst = 1'b1;
    idle(1);
    q0.delete();
    u = n_unexp0;
    send(1'b1, 1'b1, 3'd0, 64'h77);
    idle(3);
    vectors++;
    if (q0.size() != 1 || n_unexp0 != u) begin
      fails++; $display("FAIL midreset_count: got %0d beats %0d unexp required 1 0", q0.size(), n_unexp0 - u);
    end else begin
      vectors++;
      if (q0[0] !== {1'b1, 1'b1, 3'd0, 64'h77}) begin
        fails++; $display("FAIL midreset_beat: got %h required %h", q0[0], {1'b1, 1'b1, 3'd0, 64'h77});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_missing_sop();
    test_unexp_modes();
    test_overflow();
    test_back_to_back();
    test_counters();
    test_reset_mid_msg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/avalon_stream_guard.md
# avalon_stream_guard

Parametrised successor to the single-channel Avalon-ST enforcer. Repairs an untrusted Avalon-ST stream into a legal one: drops data outside messages, handles unexpected SOPs in a configurable mode, and truncates over-length messages with a forced EOP. It also masks empty bytes and keeps saturating error counters. The output is fully registered with a skid buffer, so it can close timing between a packet source and downstream consumers at full throughput.

## Interface
- DATA_WIDTH_IN_BYTES, 16, beat width in bytes; empty width is $clog2(DATA_WIDTH_IN_BYTES).
- MAX_MSG_BEATS, 256, maximum legal message length in beats (≥2).
- UNEXP_SOP_MODE, 0, 0 = strip sop and forward the beat as a continuation; 1 = drop the beat.
- CNT_WIDTH, 16, width of each error counter.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- untrusted_msg  avalon_st_if.slave  data/valid/sop/eop/empty/rdy  input stream.
- enforced_msg  avalon_st_if.master  data/valid/sop/eop/empty/rdy  repaired output stream.
- clear_counters  in  1  synchronous clear of all three counters.
- missing_sop  out  1  one-cycle pulse: a beat was dropped because it arrived outside a message.
- unexpected_sop  out  1  one-cycle pulse: a sop arrived inside a message.
- length_overflow  out  1  one-cycle pulse: a message was truncated.
- missing_sop_cnt, unexpected_sop_cnt, overflow_cnt  out  CNT_WIDTH each  saturating event counters.

## Operation
- A beat is accepted when untrusted_msg.valid and untrusted_msg.rdy are both high.
- Only accepted beats change state, counters or flags. Dropped beats are still accepted (consumed upstream) and never reach the output.
- **IDLE** (between messages)
  - Accepted beat with sop=0: drop it, pulse missing_sop.
  - Accepted beat with sop=1: forward it with sop=1 and set beat_cnt=1.
  - If that beat also has eop=1, stay in IDLE; otherwise go to IN_MSG.
- **IN_MSG**
  - Accepted beat with sop=1: pulse unexpected_sop, then apply UNEXP_SOP_MODE.
    - Mode 0: forward the beat with sop cleared; it counts toward length.
    - Mode 1: drop the beat; beat_cnt is unchanged.
  - Forwarded beat with eop=1: go to IDLE.
  - Forwarded beat with eop=0 that makes beat_cnt reach MAX_MSG_BEATS:
    - output it with eop=1 and empty=0;
    - pulse length_overflow;
    - go to DROP_TAIL.
  - A beat that carries eop exactly at MAX_MSG_BEATS is legal and causes no overflow.
- **DROP_TAIL**
  - Accepted sop=1 beat: treat exactly as in IDLE (new message); no flag.
  - Accepted sop=0 beat: drop it silently. If it has eop=1, go to IDLE.
- **Output shaping**
  - On non-eop output beats, empty is forced to 0.
  - On eop beats, empty passes through and output byte i is zeroed when i < empty. All other bytes pass unchanged.
- **Counters**
  - Each counter increments by 1 per corresponding flag pulse and saturates at 2^CNT_WIDTH−1.
  - clear_counters sets all counters to 0 and wins over a same-cycle increment; that increment is lost.

## Timing
- **Reset values**
  - enforced_msg valid/sop/eop/empty/data = 0.
  - All flags and counters = 0.
  - State IDLE, beat_cnt = 0, both buffer stages empty.
  - untrusted_msg.rdy = 0 while rst is low.
- Reset mid-message discards all buffered beats; no EOP is emitted for the interrupted message.
- **Latency and throughput**
  - A forwarded beat appears on enforced_msg exactly 1 cycle after acceptance when the output stage is free.
  - Sustained 1 beat/cycle while enforced_msg.rdy stays high.
- **Buffering and handshake**
  - The output register is backed by a one-entry skid buffer.
  - untrusted_msg.rdy = !skid_valid, taken from a register; it is not a combinational path from enforced_msg.rdy.
  - While enforced_msg.valid is high and rdy is low, enforced_msg holds stable. At most one additional beat is absorbed into the skid, after which upstream rdy drops.
  - Beats leave in acceptance order; the skid entry drains first when rdy rises.
  - A dropped beat is still accepted only when rdy is high; a full buffer stalls drops too.
- **Flags:** registered, high for exactly the one cycle after the offending beat is accepted.
- **Counter latency:** each counter value updates in the same cycle its flag goes high.

## Test plan
- Clean 3-beat message (sop / - / eop, empty=5), rdy always high → identical 3 beats out one cycle later; bytes 0..4 of the last beat zeroed; no flags.
- Two sop=0 beats in IDLE, then a 1-beat message (sop+eop) → missing_sop pulses twice, missing_sop_cnt=2, only the single-beat message is output.
- Mode 0 vs 1: sop, sop, eop → mode 0 outputs 3 beats with the second sop cleared; mode 1 outputs 2 beats. Both modes give unexpected_sop_cnt=1.
- MAX_MSG_BEATS=4, 6-beat message → 4 beats out, the 4th with eop=1 and empty=0; beats 5–6 dropped; length_overflow=1. A message of exactly 4 beats → no overflow.
- Backpressure: enforced_msg.rdy toggles randomly during 50 back-to-back beats → no loss or duplication, order kept, output stable while stalled, upstream rdy falls only after the skid fills.
- Set missing_sop_cnt to saturation (CNT_WIDTH=2, 5 events) → holds at 3. clear_counters in the same cycle as an event → 0. Assert rst mid-message → all outputs 0, next message accepted cleanly.
